// File: rtl/mult_div_unit_pkg.sv
// Shared ALU opcode definitions plus the multiply/divide unit's state
// encoding, iteration count and small arithmetic helpers.
package mult_div_unit_pkg;

  // ALU control codes shared with the ALU control decoder.
  localparam logic [3:0] OPMULT = 4'b1010;
  localparam logic [3:0] OPDIV  = 4'b1011;
  localparam logic [3:0] OPMFHI = 4'b1100;
  localparam logic [3:0] OPMFLO = 4'b1101;

  // One radix-2 step per bit of a 32-bit operand.
  localparam int         ITER_COUNT = 32;
  localparam logic [4:0] ITER_LAST  = 5'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } md_state_e;

  // Unsigned magnitude of a two's complement word; |-2^31| = 2^31 still fits.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    if (v[31]) begin
      return ~v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Conditional two's complement negation.
  function automatic logic [31:0] cneg32(input logic neg, input logic [31:0] v);
    if (neg) begin
      return ~v + 32'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// 64-bit shift/accumulate datapath: unsigned shift-add multiply or
// restoring divide, one bit per step. Upper half ends as product-high or
// remainder, lower half as product-low or quotient.
module md_iter_core
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] load_lo,
  input  logic [31:0] load_opnd,
  output logic [63:0] acc
);

  logic [63:0] acc_r;
  logic [63:0] acc_nx_s;
  logic [31:0] opnd_r;
  logic [32:0] sum_s;
  logic [32:0] trial_s;

  // Next accumulator value for one multiply or divide iteration.
  always_comb begin
    sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
    trial_s = acc_r[63:31] - {1'b0, opnd_r};
    if (is_div) begin
      if (trial_s[32]) begin
        acc_nx_s = {acc_r[62:0], 1'b0};
      end else begin
        acc_nx_s = {trial_s[31:0], acc_r[30:0], 1'b1};
      end
    end else begin
      acc_nx_s = {sum_s, acc_r[31:1]};
    end
  end

  // Accumulator and fixed operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= 64'd0;
      opnd_r <= 32'd0;
    end else if (load) begin
      acc_r  <= {32'd0, load_lo};
      opnd_r <= load_opnd;
    end else if (step) begin
      acc_r  <= acc_nx_s;
    end else begin
      acc_r  <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed MULT/DIV unit with architectural HI/LO registers,
// zero-latency MFHI/MFLO reads and a pipeline stall/kill interface.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic [3:0]  iControlSignal,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iKill,
  output logic [31:0] oResult,
  output logic        oStall,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  md_state_e   state_r, state_nx;
  logic [4:0]  cnt_r;
  logic        op_div_r, neg_lo_r, neg_hi_r, div_zero_r;
  logic [31:0] hi_r, lo_r;
  logic        accept_s, step_s, write_s;
  logic        is_muldiv_s, is_mf_s, busy_s;
  logic [63:0] acc_s, prod_s;
  logic [31:0] fin_hi_s, fin_lo_s;
  logic [31:0] load_lo_s, load_opnd_s;

  assign is_muldiv_s = (iControlSignal == OPMULT) || (iControlSignal == OPDIV);
  assign is_mf_s     = (iControlSignal == OPMFHI) || (iControlSignal == OPMFLO);
  assign busy_s      = (state_r != S_IDLE);

  // Divide iterates over the dividend, multiply over the multiplier (rt).
  assign load_lo_s   = (iControlSignal == OPDIV) ? mag32(iA) : mag32(iB);
  assign load_opnd_s = (iControlSignal == OPDIV) ? mag32(iB) : mag32(iA);

  md_iter_core u_core (
    .clk       (iClk),
    .rst_n     (iReset_n),
    .load      (accept_s),
    .step      (step_s),
    .is_div    (op_div_r),
    .load_lo   (load_lo_s),
    .load_opnd (load_opnd_s),
    .acc       (acc_s)
  );

  // Next state and control strobes; kill beats both issue and write-back.
  always_comb begin
    state_nx = state_r;
    accept_s = 1'b0;
    step_s   = 1'b0;
    write_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (iKill) begin
          state_nx = S_IDLE;
        end else if (iStart && is_muldiv_s) begin
          accept_s = 1'b1;
          state_nx = S_RUN;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (iKill) begin
          state_nx = S_IDLE;
        end else begin
          step_s = 1'b1;
          if (cnt_r == ITER_LAST) begin
            state_nx = S_FINISH;
          end else begin
            state_nx = S_RUN;
          end
        end
      end
      S_FINISH: begin
        if (iKill) begin
          state_nx = S_IDLE;
        end else begin
          write_s  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sign correction of the unsigned core result; div-by-zero forces LO to all ones.
  always_comb begin
    prod_s = neg_lo_r ? (~acc_s + 64'd1) : acc_s;
    if (op_div_r) begin
      fin_hi_s = cneg32(neg_hi_r, acc_s[63:32]);
      if (div_zero_r) begin
        fin_lo_s = 32'hFFFF_FFFF;
      end else begin
        fin_lo_s = cneg32(neg_lo_r, acc_s[31:0]);
      end
    end else begin
      fin_hi_s = prod_s[63:32];
      fin_lo_s = prod_s[31:0];
    end
  end

  // State register.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Iteration counter and operation attributes captured at issue.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt_r      <= 5'd0;
      op_div_r   <= 1'b0;
      neg_lo_r   <= 1'b0;
      neg_hi_r   <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (accept_s) begin
      cnt_r      <= 5'd0;
      op_div_r   <= (iControlSignal == OPDIV);
      neg_lo_r   <= iA[31] ^ iB[31];
      neg_hi_r   <= iA[31];
      div_zero_r <= (iB == 32'd0);
    end else if (step_s) begin
      cnt_r      <= cnt_r + 5'd1;
    end else begin
      cnt_r      <= cnt_r;
    end
  end

  // Architectural HI/LO, written only by an unkilled FINISH.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (write_s) begin
      hi_r <= fin_hi_s;
      lo_r <= fin_lo_s;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Read port: only an idle-unit MFHI/MFLO issue drives data.
  always_comb begin
    if (iStart && !busy_s && (iControlSignal == OPMFHI)) begin
      oResult = hi_r;
    end else if (iStart && !busy_s && (iControlSignal == OPMFLO)) begin
      oResult = lo_r;
    end else begin
      oResult = 32'd0;
    end
  end

  assign oStall = iStart && (is_muldiv_s || is_mf_s) && busy_s;
  assign oBusy  = busy_s;
  assign oDone  = write_s;
  assign oHI    = hi_r;
  assign oLO    = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal
// expectations plus randomized traffic against a timeline-based model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iStart = 1'b0;
  logic [3:0]  iControlSignal = 4'h0;
  logic [31:0] iA = 32'd0;
  logic [31:0] iB = 32'd0;
  logic        iKill = 1'b0;
  logic [31:0] oResult, oHI, oLO;
  logic        oStall, oBusy, oDone;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: committed HI/LO, pending result, cycles left until write.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  int          m_left = 0;

  mult_div_unit dut (
    .iClk(iClk), .iReset_n(iReset_n), .iStart(iStart),
    .iControlSignal(iControlSignal), .iA(iA), .iB(iB), .iKill(iKill),
    .oResult(oResult), .oStall(oStall), .oBusy(oBusy), .oDone(oDone),
    .oHI(oHI), .oLO(oLO)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Architectural result of a MULT/DIV from plain 64-bit arithmetic.
  function automatic void predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, pr, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OPMULT) begin
      pr = sa * sb;
      hi = pr[63:32];
      lo = pr[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Model: an accepted op writes 33 edges later unless killed or reset.
  always @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      if (iKill) m_left = 0;
      else if (m_left == 1) begin
        m_hi = p_hi; m_lo = p_lo; m_left = 0;
      end else m_left--;
    end else if (!iKill && iStart && (iControlSignal == OPMULT || iControlSignal == OPDIV)) begin
      predict(iControlSignal, iA, iB, p_hi, p_lo);
      m_left = 33;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge iClk) begin : cmp
    logic busy_e, done_e, stall_e, act_e;
    logic [31:0] res_e;
    busy_e  = (m_left > 0);
    done_e  = (m_left == 1) && !iKill;
    act_e   = (iControlSignal == OPMULT) || (iControlSignal == OPDIV) ||
              (iControlSignal == OPMFHI) || (iControlSignal == OPMFLO);
    stall_e = iStart && act_e && busy_e;
    if (iStart && !busy_e && iControlSignal == OPMFHI) res_e = m_hi;
    else if (iStart && !busy_e && iControlSignal == OPMFLO) res_e = m_lo;
    else res_e = 32'd0;
    chk("busy",   {31'd0, oBusy},  {31'd0, busy_e});
    chk("done",   {31'd0, oDone},  {31'd0, done_e});
    chk("stall",  {31'd0, oStall}, {31'd0, stall_e});
    chk("result", oResult, res_e);
    chk("hi",     oHI, m_hi);
    chk("lo",     oLO, m_lo);
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Issue one op, measure cycles from issue to oDone, then check HI/LO literals.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    iStart = 1'b1; iControlSignal = op; iA = a; iB = b;
    tick();
    iStart = 1'b0; iControlSignal = 4'h0;
    cyc = 1;
    while (cyc < 40) begin
      @(negedge iClk);
      if (oDone) break;
      cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd33);
    tick();
    @(negedge iClk);
    chk({nm, " HI"}, oHI, ehi);
    chk({nm, " LO"}, oLO, elo);
    chk({nm, " model HI"}, m_hi, ehi);
    chk({nm, " model LO"}, m_lo, elo);
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] ehi, elo, prev_hi, prev_lo;
    int cyc;
    logic saw_done;

    repeat (3) tick();
    @(negedge iClk);
    chk("reset HI", oHI, 32'd0);
    chk("reset LO", oLO, 32'd0);
    chk("reset busy", {31'd0, oBusy}, 32'd0);
    chk("reset result", oResult, 32'd0);
    tick();
    iReset_n = 1'b1;
    repeat (2) tick();

    run_op("mult 7*-3", OPMULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div -7/2", OPDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 5/0", OPDIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div min/-1", OPDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("div 100/-7", OPDIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);

    // MFLO issued 10 cycles into a MULT stalls until oDone, then reads new LO.
    predict(OPMULT, 32'h1234_5678, 32'hFEDC_BA98, ehi, elo);
    iStart = 1'b1; iControlSignal = OPMULT; iA = 32'h1234_5678; iB = 32'hFEDC_BA98;
    tick();
    iStart = 1'b0; iControlSignal = 4'h0;
    repeat (9) tick();
    iStart = 1'b1; iControlSignal = OPMFLO;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge iClk);
      chk("mflo held stall", {31'd0, oStall}, 32'd1);
      if (oDone) break;
      cyc++;
    end
    chk("mflo stall reached done", {31'd0, oDone}, 32'd1);
    tick();
    @(negedge iClk);
    chk("mflo after done stall", {31'd0, oStall}, 32'd0);
    chk("mflo after done data", oResult, elo);
    tick();
    iStart = 1'b0; iControlSignal = 4'h0;
    tick();

    // Kill in RUN cycle 15 leaves HI/LO alone and yields no oDone.
    prev_hi = ehi; prev_lo = elo;
    iStart = 1'b1; iControlSignal = OPMULT; iA = 32'd3; iB = 32'd5;
    tick();
    iStart = 1'b0; iControlSignal = 4'h0;
    repeat (14) tick();
    iKill = 1'b1;
    tick();
    iKill = 1'b0;
    @(negedge iClk);
    chk("kill busy", {31'd0, oBusy}, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (oDone) saw_done = 1'b1;
    end
    chk("kill no done", {31'd0, saw_done}, 32'd0);
    chk("kill HI kept", oHI, prev_hi);
    chk("kill LO kept", oLO, prev_lo);

    // Reset mid-RUN clears immediately; MULT on first edge after release works.
    iStart = 1'b1; iControlSignal = OPMULT; iA = 32'd11; iB = 32'd13;
    tick();
    iStart = 1'b0; iControlSignal = 4'h0;
    repeat (10) tick();
    iReset_n = 1'b0;
    #1;
    chk("rst busy", {31'd0, oBusy}, 32'd0);
    chk("rst HI", oHI, 32'd0);
    chk("rst LO", oLO, 32'd0);
    tick();
    tick();
    iReset_n = 1'b1;
    run_op("mult after reset", OPMULT, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFD3);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      iStart = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0, 1: iControlSignal = OPMULT;
        2, 3: iControlSignal = OPDIV;
        4, 5: iControlSignal = OPMFHI;
        6, 7: iControlSignal = OPMFLO;
        default: iControlSignal = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 7))
        0: iA = 32'h8000_0000;
        1: iA = 32'($urandom_range(0, 20)) - 32'd10;
        default: iA = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: iB = 32'd0;
        1: iB = 32'hFFFF_FFFF;
        2: iB = 32'($urandom_range(0, 20)) - 32'd10;
        default: iB = $urandom;
      endcase
      iKill = ($urandom_range(0, 99) == 0);
      tick();
    end
    iStart = 1'b0; iKill = 1'b0; iControlSignal = 4'h0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
